// File: rtl/at_resp_decoder.sv
// at_resp_decoder
// Receive-side parser for the GSM modem link. Splits the UART byte stream
// into CR-terminated lines and recognises the responses the SMS command
// sequencer waits on (OK, ERROR, +CPMS:, +CMTI: and the "> " prompt).
// The storage index of a +CMTI notification is extracted as msg_no.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   rx_data    byte from UART receiver
//   rx_valid   one-cycle strobe, rx_data valid this cycle
//   ctrl_clr   one-cycle strobe, clears ctrl to 0 (a same-cycle code load wins)
//   ctrl       sticky response code: 0 none, 1 OK, 2 +CPMS:, 3 ERROR,
//              4 +CMTI:, 6 prompt
//   msg_no     index from the most recent valid +CMTI line, saturating at 255
//   line_done  one-cycle pulse whenever ctrl is loaded with a new code
module at_resp_decoder #(
  parameter int LINE_MAX = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       ctrl_clr,
  output logic [2:0] ctrl,
  output logic [7:0] msg_no,
  output logic       line_done
);

  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_GT    = 8'h3E;
  localparam logic [7:0] CH_COMMA = 8'h2C;

  localparam logic [2:0] CODE_OK     = 3'd1;
  localparam logic [2:0] CODE_CPMS   = 3'd2;
  localparam logic [2:0] CODE_ERROR  = 3'd3;
  localparam logic [2:0] CODE_CMTI   = 3'd4;
  localparam logic [2:0] CODE_PROMPT = 3'd6;

  // Flag index: 0 OK, 1 ERROR, 2 +CPMS:, 3 +CMTI:. Patterns are left-aligned
  // in 48 bits so byte i of the pattern is always at the same slice.
  localparam logic [47:0] PAT [0:3] = '{
    {"OK", 32'h0},
    {"ERROR", 8'h0},
    "+CPMS:",
    "+CMTI:"
  };
  localparam logic [2:0] PLEN [0:3] = '{3'd2, 3'd5, 3'd6, 3'd6};

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    BODY,
    SKIP,
    DISCARD
  } state_t;

  state_t     state_reg;
  logic [6:0] pos_reg;
  logic [3:0] flags_reg;
  logic [3:0] flags_next;
  logic [7:0] acc_reg;
  logic [7:0] acc_next;
  logic       got_comma_reg;
  logic       got_digit_reg;
  logic [11:0] acc_mul;
  logic       is_digit;
  logic       at_max;
  logic       is_cr;
  logic       take;

  function automatic logic [7:0] pat_byte(input logic [47:0] p, input logic [2:0] i);
    case (i)
      3'd0:    return p[47:40];
      3'd1:    return p[39:32];
      3'd2:    return p[31:24];
      3'd3:    return p[23:16];
      3'd4:    return p[15:8];
      3'd5:    return p[7:0];
      default: return 8'h00;
    endcase
  endfunction

  // A candidate survives while every byte inside its pattern length matches.
  // Bytes beyond the pattern leave the flag alone; the line-length test at
  // CR decides whether the extra bytes disqualify the line.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_flag
      assign flags_next[gi] = flags_reg[gi] &
                              ((pos_reg >= {4'd0, PLEN[gi]}) |
                               (rx_data == pat_byte(PAT[gi], pos_reg[2:0])));
    end
  endgenerate

  assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  // acc*10 + 9 fits in 12 bits for any 8-bit acc, so the saturation test is exact.
  assign acc_mul  = ({4'd0, acc_reg} * 12'd10) + {4'd0, (rx_data - 8'h30)};
  assign acc_next = (acc_mul > 12'd255) ? 8'hFF : acc_mul[7:0];
  // pos_reg already equals the line length; one more byte would overflow.
  assign at_max   = (pos_reg == 7'(LINE_MAX));
  assign is_cr    = (rx_data == CH_CR);
  assign take     = rx_valid && (rx_data != CH_LF);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      pos_reg       <= 7'd0;
      flags_reg     <= 4'hF;
      acc_reg       <= 8'd0;
      got_comma_reg <= 1'b0;
      got_digit_reg <= 1'b0;
      ctrl          <= 3'd0;
      msg_no        <= 8'd0;
      line_done     <= 1'b0;
    end else begin
      line_done <= 1'b0;
      // Any code load below overrides this clear in the same cycle.
      if (ctrl_clr) begin
        ctrl <= 3'd0;
      end

      if (take) begin
        case (state_reg)
          IDLE: begin
            if (is_cr) begin
              // empty line
            end else if (rx_data == CH_GT) begin
              // The prompt is never followed by CR, so it is reported at once.
              ctrl      <= CODE_PROMPT;
              line_done <= 1'b1;
            end else begin
              pos_reg       <= 7'd1;
              flags_reg     <= flags_next;
              acc_reg       <= 8'd0;
              got_comma_reg <= 1'b0;
              got_digit_reg <= 1'b0;
              state_reg     <= HDR;
            end
          end

          HDR: begin
            if (is_cr) begin
              if (flags_reg[0] && (pos_reg == 7'd2)) begin
                ctrl      <= CODE_OK;
                line_done <= 1'b1;
              end else if (flags_reg[1] && (pos_reg == 7'd5)) begin
                ctrl      <= CODE_ERROR;
                line_done <= 1'b1;
              end else if (flags_reg[2] && (pos_reg >= 7'd6)) begin
                ctrl      <= CODE_CPMS;
                line_done <= 1'b1;
              end
              pos_reg   <= 7'd0;
              flags_reg <= 4'hF;
              state_reg <= IDLE;
            end else if (at_max) begin
              state_reg <= DISCARD;
            end else begin
              pos_reg   <= pos_reg + 7'd1;
              flags_reg <= flags_next;
              // Decision point: this byte is the sixth of the line.
              if (pos_reg == 7'd5) begin
                if (flags_next[3]) begin
                  state_reg <= BODY;
                end else if (flags_next == 4'd0) begin
                  state_reg <= SKIP;
                end
              end
            end
          end

          BODY: begin
            if (is_cr) begin
              if (got_digit_reg) begin
                msg_no    <= acc_reg;
                ctrl      <= CODE_CMTI;
                line_done <= 1'b1;
              end
              pos_reg   <= 7'd0;
              flags_reg <= 4'hF;
              state_reg <= IDLE;
            end else if (at_max) begin
              state_reg <= DISCARD;
            end else begin
              pos_reg <= pos_reg + 7'd1;
              // Each comma restarts the index, so the field after the last
              // comma is the one reported.
              if (rx_data == CH_COMMA) begin
                acc_reg       <= 8'd0;
                got_comma_reg <= 1'b1;
                got_digit_reg <= 1'b0;
              end else if (got_comma_reg && is_digit) begin
                acc_reg       <= acc_next;
                got_digit_reg <= 1'b1;
              end
            end
          end

          SKIP: begin
            if (is_cr) begin
              pos_reg   <= 7'd0;
              flags_reg <= 4'hF;
              state_reg <= IDLE;
            end else if (at_max) begin
              state_reg <= DISCARD;
            end else begin
              pos_reg <= pos_reg + 7'd1;
            end
          end

          DISCARD: begin
            if (is_cr) begin
              pos_reg   <= 7'd0;
              flags_reg <= 4'hF;
              state_reg <= IDLE;
            end
          end

          default: begin
            pos_reg   <= 7'd0;
            flags_reg <= 4'hF;
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_at_resp_decoder.sv
// Self-checking bench for at_resp_decoder. A line-level reference model
// classifies each completed line by string comparison and queues the
// expected code load; an independent monitor pops the queue on every
// line_done pulse and checks code, index and latency.
module tb_at_resp_decoder;

  localparam int LINE_MAX = 64;
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       rx_valid = 1'b0;
  logic       ctrl_clr = 1'b0;
  logic [2:0] ctrl;
  logic [7:0] msg_no;
  logic       line_done;

  at_resp_decoder #(.LINE_MAX(LINE_MAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .ctrl_clr  (ctrl_clr),
    .ctrl      (ctrl),
    .msg_no    (msg_no),
    .line_done (line_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     code;
    int     msg;
    longint cyc;
  } exp_t;

  exp_t   exp_q[$];
  byte    line_q[$];
  int     m_ctrl = 0;
  int     m_msg = 0;
  int     m_loads = 0;
  int     n_done = 0;
  int     n_checks = 0;
  int     n_pass = 0;
  longint cyc = 0;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
  endtask

  // ---------------- reference model ----------------
  function automatic bit has_prefix(input string p);
    if (line_q.size() < p.len()) return 1'b0;
    for (int i = 0; i < p.len(); i++)
      if (line_q[i] != p[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic load(input int code, input int msg);
    m_ctrl = code;
    if (code == 4) m_msg = msg;
    m_loads++;
    exp_q.push_back('{code, m_msg, cyc + 1});
  endtask

  task automatic eval_line();
    int n, lc, val;
    bit gd;
    n = line_q.size();
    if (n > LINE_MAX) return;
    if (n == 2 && has_prefix("OK")) load(1, 0);
    else if (n == 5 && has_prefix("ERROR")) load(3, 0);
    else if (has_prefix("+CPMS:")) load(2, 0);
    else if (has_prefix("+CMTI:")) begin
      lc = -1;
      for (int i = 6; i < n; i++) if (line_q[i] == 8'h2C) lc = i;
      if (lc < 0) return;
      val = 0;
      gd = 1'b0;
      for (int i = lc + 1; i < n; i++) begin
        if (line_q[i] >= 8'h30 && line_q[i] <= 8'h39) begin
          val = val * 10 + (line_q[i] - 8'h30);
          if (val > 255) val = 256;
          gd = 1'b1;
        end
      end
      if (gd) load(4, (val > 255) ? 255 : val);
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b == LF) return;
    if (b == CR) begin
      if (line_q.size() > 0) eval_line();
      line_q.delete();
    end else if (line_q.size() == 0 && b == 8'h3E) begin
      load(6, 0);
    end else begin
      line_q.push_back(byte'(b));
    end
  endtask

  task automatic model_reset();
    line_q.delete();
    exp_q.delete();
    m_ctrl = 0;
    m_msg = 0;
  endtask

  // ---------------- monitor ----------------
  initial forever begin
    @(negedge clk);
    if (rst && line_done) begin
      exp_t e;
      n_done++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_line_done: got ctrl=%0d msg_no=%0d, expected no pulse", ctrl, msg_no);
      end else begin
        e = exp_q.pop_front();
        chk("done_ctrl", int'(ctrl), e.code);
        chk("done_msg_no", int'(msg_no), e.msg);
        chk("done_latency", int'(cyc), int'(e.cyc));
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic drive(input logic [7:0] b, input bit v, input bit clr);
    @(negedge clk);
    rx_data  = b;
    rx_valid = v;
    ctrl_clr = clr;
    if (clr) m_ctrl = 0;
    if (v) model_byte(b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(8'd0, 1'b0, 1'b0);
  endtask

  task automatic send_raw(input string s, input bit gaps);
    for (int i = 0; i < s.len(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) idle(1);
      if (gaps && $urandom_range(0, 15) == 0) drive(LF, 1'b1, 1'b0);
      drive(s[i], 1'b1, gaps && ($urandom_range(0, 19) == 0));
    end
  endtask

  task automatic send_line(input string s, input bit gaps);
    send_raw(s, gaps);
    drive(CR, 1'b1, 1'b0);
  endtask

  task automatic settle(input string name);
    idle(3);
    chk({name, "_ctrl"}, int'(ctrl), m_ctrl);
    chk({name, "_msg_no"}, int'(msg_no), m_msg);
  endtask

  string junk_set = "OKER+CMTIPS:, 0123456789A\"";

  task automatic random_line();
    string s;
    int k, len;
    k = $urandom_range(0, 7);
    case (k)
      0: s = "OK";
      1: s = "ERROR";
      2: s = $sformatf("+CPMS: %0d,30,%0d,30", $urandom_range(0, 30), $urandom_range(0, 30));
      3: s = $sformatf("+CMTI: \"SM\",%0d", $urandom_range(0, 400));
      4: s = ($urandom_range(0, 1) == 0) ? "+CMTI: \"SM\"" : $sformatf("+CMTI: \"SM\",%0d%0d", $urandom_range(1, 99), $urandom_range(100, 999));
      5: begin
        s = "";
        len = $urandom_range(0, 72);
        for (int i = 0; i < len; i++)
          s = {s, junk_set.substr($urandom_range(0, junk_set.len() - 1), 0)};
      end
      6: begin
        case ($urandom_range(0, 4))
          0: s = "OK ";
          1: s = "ERRO";
          2: s = "+CPMS";
          3: s = "+CMTX: \"SM\",5";
          default: s = "ERRORS";
        endcase
      end
      default: s = "";
    endcase
    if (k == 7) send_raw(">", 1'b1);
    else send_line(s, 1'b1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", int'(ctrl), 0);
    chk("reset_msg_no", int'(msg_no), 0);
    chk("reset_line_done", int'(line_done), 0);
    @(negedge clk);
    rst = 1'b1;

    // "\r\nOK\r\n"
    drive(CR, 1'b1, 1'b0);
    drive(LF, 1'b1, 1'b0);
    send_line("OK", 1'b0);
    drive(LF, 1'b1, 1'b0);
    settle("ok");

    send_line("+CPMS: 0,30,0,30", 1'b0);
    settle("cpms");
    drive(8'd0, 1'b0, 1'b1);
    settle("clear");
    send_line("ERROR", 1'b0);
    settle("error");

    send_line("+CMTI: \"SM\",7", 1'b0);
    settle("cmti7");
    send_line("+CMTI: \"SM\",300", 1'b0);
    settle("cmti300");

    send_raw("> ", 1'b0);
    settle("prompt");
    send_line("OKAY", 1'b0);
    send_line("+CMTI: \"SM\"", 1'b0);
    settle("no_code");

    // Overlong line, back-to-back bytes.
    for (int i = 0; i < 70; i++) drive("A", 1'b1, 1'b0);
    drive(CR, 1'b1, 1'b0);
    send_line("OK", 1'b0);
    settle("overflow");

    // Reset in the middle of a +CMTI line.
    send_raw("+CMT", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    rx_valid = 1'b0;
    model_reset();
    #1;
    chk("midreset_ctrl", int'(ctrl), 0);
    chk("midreset_msg_no", int'(msg_no), 0);
    chk("midreset_line_done", int'(line_done), 0);
    @(negedge clk);
    rst = 1'b1;
    send_line("I: \"SM\",2", 1'b0);
    settle("after_reset");

    // Randomised traffic with gaps, stray LFs and ctrl_clr strobes.
    for (int n = 0; n < 300; n++) begin
      random_line();
      if ($urandom_range(0, 3) == 0) settle("rand");
    end
    settle("final");

    chk("pending_expectations", exp_q.size(), 0);
    chk("line_done_count", n_done, m_loads);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got %0d checks", n_checks);
    $fatal(1, "timeout");
  end

endmodule
